// File: rtl/netwalk_tcam_pkg.sv
// Shared TCAM definitions: flow address width, group sizing and the {hit, addr} result record
// consumed by the action stage.
package netwalk_tcam_pkg;

    localparam int TCAM_ADDR_WIDTH  = 10;
    localparam int TCAM_NUM_ENTRIES = 16;
    localparam int TCAM_GROUP_WIDTH = 4;
    localparam int NUM_GROUPS       = TCAM_NUM_ENTRIES / TCAM_GROUP_WIDTH;

    typedef struct packed {
        logic                       hit;
        logic [TCAM_ADDR_WIDTH-1:0] addr;
    } tcam_result_t;

    // Index width of a WIDTH-bit encoder; a 1-bit encoder still carries a 1-bit index.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tcam_match_resolver_if.sv
// Match-vector input and flow-result output of the TCAM priority resolver, both valid/ready.
// The slave modport is the resolver; the master modport is the match array plus action stage.
interface tcam_match_resolver_if #(
    parameter int NUM_ENTRIES     = 16,
    parameter int TCAM_ADDR_WIDTH = 10,
    parameter int STAT_WIDTH      = 32
);
    logic [NUM_ENTRIES-1:0]     match_vec;
    logic [NUM_ENTRIES-1:0]     entry_valid;
    logic                       match_valid;
    logic                       match_ready;
    logic                       result_valid;
    logic                       result_ready;
    logic                       result_hit;
    logic [TCAM_ADDR_WIDTH-1:0] result_addr;
    logic                       stat_clear;
    logic [STAT_WIDTH-1:0]      stat_lookups;
    logic [STAT_WIDTH-1:0]      stat_hits;

    modport master (
        output match_vec, entry_valid, match_valid, result_ready, stat_clear,
        input  match_ready, result_valid, result_hit, result_addr, stat_lookups, stat_hits
    );

    modport slave (
        input  match_vec, entry_valid, match_valid, result_ready, stat_clear,
        output match_ready, result_valid, result_hit, result_addr, stat_lookups, stat_hits
    );
endinterface

// File: rtl/tcam_prio_enc.sv
// Lowest-set-bit encoder with any-flag; purely combinational, no handshake.
// idx_o is 0 when no bit is set.
module tcam_prio_enc
    import netwalk_tcam_pkg::idx_width;
#(
    parameter  int WIDTH = 4,
    localparam int IDXW  = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             any_o,
    output logic [IDXW-1:0]  idx_o
);

    assign any_o = |vec_i;

    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDXW'(i);
        end
    end

endmodule

// File: rtl/tcam_match_resolver.sv
// Two-stage lowest-index TCAM hit resolver, result 2 cycles after acceptance, 1 lookup/cycle;
// stalls S2 then S1 under result backpressure. Counters compiled in with TCAM_RESOLVER_STATS_EN.
module tcam_match_resolver
    import netwalk_tcam_pkg::tcam_result_t;
    import netwalk_tcam_pkg::idx_width;
#(
    parameter int NUM_ENTRIES     = 16,
    parameter int TCAM_ADDR_WIDTH = 10,
    parameter int GROUP_WIDTH     = 4,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    tcam_match_resolver_if.slave  bus
);

    localparam int NGROUPS = NUM_ENTRIES / GROUP_WIDTH;
    localparam int GIW     = idx_width(GROUP_WIDTH);
    localparam int SIW     = idx_width(NGROUPS);

    logic [NUM_ENTRIES-1:0]     eff;
    logic [NGROUPS-1:0]         grp_any;
    logic [GIW-1:0]             grp_idx [NGROUPS];
    logic [NGROUPS-1:0]         any_q;
    logic [GIW-1:0]             idx_q   [NGROUPS];
    logic                       sel_any;
    logic [SIW-1:0]             sel_grp;
    logic [TCAM_ADDR_WIDTH-1:0] sel_addr;
    tcam_result_t               res_d, res_q;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load, accept;

    assign eff = bus.match_vec & bus.entry_valid;

    for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
        tcam_prio_enc #(.WIDTH(GROUP_WIDTH)) u_grp_enc (
            .vec_i (eff[g*GROUP_WIDTH +: GROUP_WIDTH]),
            .any_o (grp_any[g]),
            .idx_o (grp_idx[g])
        );
    end

    tcam_prio_enc #(.WIDTH(NGROUPS)) u_sel_enc (
        .vec_i (any_q),
        .any_o (sel_any),
        .idx_o (sel_grp)
    );

    // Stage occupancy register
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Next-state: S2 advances when empty or drained, S1 when empty or S2 advances
    always_comb begin
        s2_load    = !s2_valid_q || bus.result_ready;
        s1_load    = !s1_valid_q || s2_load;
        accept     = bus.match_valid && s1_load;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (s2_load) s2_valid_d = s1_valid_q;
        if (s1_load) s1_valid_d = bus.match_valid;
    end

    always_comb begin
        bus.match_ready  = s1_load;
        bus.result_valid = s2_valid_q;
        bus.result_hit   = res_q.hit;
        bus.result_addr  = TCAM_ADDR_WIDTH'(res_q.addr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            any_q <= '0;
            for (int g = 0; g < NGROUPS; g++) idx_q[g] <= '0;
        end else if (accept) begin
            any_q <= grp_any;
            for (int g = 0; g < NGROUPS; g++) idx_q[g] <= grp_idx[g];
        end
    end

    always_comb begin
        sel_addr  = TCAM_ADDR_WIDTH'(sel_grp) * TCAM_ADDR_WIDTH'(GROUP_WIDTH)
                  + TCAM_ADDR_WIDTH'(idx_q[sel_grp]);
        res_d.hit  = sel_any;
        res_d.addr = sel_any ? sel_addr : '0;
    end

    // Result only moves when S2 advances, so it is held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q <= '0;
        end else if (s2_load && s1_valid_q) begin
            res_q <= res_d;
        end
    end

`ifdef TCAM_RESOLVER_STATS_EN
    logic [STAT_WIDTH-1:0] lookups_q, lookups_d;
    logic [STAT_WIDTH-1:0] hits_q, hits_d;
    logic                  deliver;

    assign deliver = s2_valid_q && bus.result_ready;

    always_comb begin
        lookups_d = lookups_q;
        hits_d    = hits_q;
        if (bus.stat_clear) begin
            lookups_d = '0;
            hits_d    = '0;
        end else if (deliver) begin
            if (lookups_q != '1)              lookups_d = lookups_q + 1'b1;
            if (res_q.hit && (hits_q != '1))  hits_d    = hits_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end

    assign bus.stat_lookups = lookups_q;
    assign bus.stat_hits    = hits_q;
`else
    logic unused_stat_clear;

    assign unused_stat_clear = bus.stat_clear;
    assign bus.stat_lookups  = {STAT_WIDTH{1'b0}};
    assign bus.stat_hits     = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_tcam_match_resolver.sv
// Randomised and directed bench for tcam_match_resolver against an in-order queue model.
module tb_tcam_match_resolver;

    localparam int NE    = 16;
    localparam int AW    = 10;
    localparam int GW    = 4;
    localparam int SW    = 5;
    localparam int SMAXI = (1 << SW) - 1;

    typedef struct {
        logic          hit;
        logic [AW-1:0] addr;
        int            t;
    } exp_t;

    typedef logic [1+1+AW+1+SW+SW-1:0] obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tcam_match_resolver_if #(.NUM_ENTRIES(NE), .TCAM_ADDR_WIDTH(AW), .STAT_WIDTH(SW)) bus ();

    tcam_match_resolver #(
        .NUM_ENTRIES(NE), .TCAM_ADDR_WIDTH(AW), .GROUP_WIDTH(GW), .STAT_WIDTH(SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   m_look = 0;
    int   m_hits = 0;

    // Highest priority flow is the lowest programmed entry that matched
    function automatic exp_t lookup(input logic [NE-1:0] vec, input logic [NE-1:0] ev, input int t);
        exp_t e;
        e.hit = 1'b0; e.addr = '0; e.t = t;
        for (int i = 0; i < NE; i++) begin
            if (vec[i] && ev[i]) begin
                e.hit = 1'b1; e.addr = AW'(i);
                return e;
            end
        end
        return e;
    endfunction

    // One clock: sample outputs, drive inputs, predict, advance the model, step to next negedge.
    task automatic cycle(input logic mv, input logic [NE-1:0] vec, input logic [NE-1:0] ev,
                         input logic rr, input logic sc, output obs_t got, output obs_t exp);
        logic           ex_v, ex_r;
        logic           g_hit;
        logic [AW-1:0]  g_addr;
        logic [SW-1:0]  e_look, e_hits;
        exp_t           h;
        ex_v = (q.size() > 0) && (cyc >= q[0].t + 1);
        h.hit = 1'b0; h.addr = '0; h.t = 0;
        if (ex_v) h = q[0];
        bus.match_valid  = mv;
        bus.match_vec    = vec;
        bus.entry_valid  = ev;
        bus.result_ready = rr;
        bus.stat_clear   = sc;
        #1;
        ex_r   = (q.size() < 2) || rr;
        g_hit  = ex_v ? bus.result_hit  : 1'b0;
        g_addr = ex_v ? bus.result_addr : '0;
`ifdef TCAM_RESOLVER_STATS_EN
        e_look = SW'(m_look);
        e_hits = SW'(m_hits);
`else
        e_look = '0;
        e_hits = '0;
`endif
        got = {bus.result_valid, g_hit, g_addr, bus.match_ready, bus.stat_lookups, bus.stat_hits};
        exp = {ex_v, h.hit, h.addr, ex_r, e_look, e_hits};
        if (sc) begin
            m_look = 0; m_hits = 0;
        end else if (ex_v && rr) begin
            if (m_look < SMAXI) m_look++;
            if (h.hit && m_hits < SMAXI) m_hits++;
        end
        if (ex_v && rr) void'(q.pop_front());
        if (mv && ex_r) q.push_back(lookup(vec, ev, cyc + 1));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.match_valid = 1'b0; bus.match_vec = '0; bus.entry_valid = '0;
        bus.result_ready = 1'b0; bus.stat_clear = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_look = 0; m_hits = 0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        apply_reset();
        #1;
        got = {bus.result_valid, bus.result_hit, bus.result_addr, bus.match_ready,
               bus.stat_lookups, bus.stat_hits};
        total++;
        if (got !== {1'b0, 1'b0, AW'(0), 1'b1, SW'(0), SW'(0)}) begin
            bad++; $display("FAIL reset_state got=%h exp v=0 hit=0 addr=0 rdy=1 stats=0", got);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    task automatic test_single();
        obs_t got, exp;
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 16'h0120, 16'hFFFF, 1'b1, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    task automatic test_boundaries();
        obs_t          got, exp;
        logic [NE-1:0] vecs [4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h8000};
        logic [NE-1:0] evs  [4] = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h7FFF};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) cycle(1'b1, vecs[i], evs[i], 1'b1, 1'b0, got, exp);
            else       cycle(1'b0, '0, '0, 1'b1, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL boundary cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        for (int i = 0; i < 11; i++) begin
            cycle(i < 8, NE'(1) << (i % 8), 16'hFFFF, 1'b1, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    task automatic test_backpressure();
        obs_t got, exp;
        for (int i = 0; i < 9; i++) begin
            cycle(i < 4, NE'(16'h0100) << i, 16'hFFFF, i >= 5, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    task automatic test_reset_midflight();
        obs_t got, exp;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, NE'(16'h0006) << i, 16'hFFFF, 1'b0, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL midflight_fill cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        apply_reset();
        #1;
        total++;
        if ({bus.result_valid, bus.result_hit, bus.result_addr, bus.match_ready} !== {1'b0, 1'b0, AW'(0), 1'b1}) begin
            bad++; $display("FAIL midflight_reset got v=%b hit=%b addr=%0d rdy=%b exp v=0 hit=0 addr=0 rdy=1",
                            bus.result_valid, bus.result_hit, bus.result_addr, bus.match_ready);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL midflight_stale cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

`ifdef TCAM_RESOLVER_STATS_EN
    task automatic test_stats();
        obs_t got, exp;
        cycle(1'b0, '0, '0, 1'b1, 1'b1, got, exp);
        for (int i = 0; i < 13; i++) begin
            cycle(i < 10, (i < 6) ? (NE'(1) << i) : '0, 16'hFFFF, 1'b1, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL stats_count cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        total++;
        if (bus.stat_lookups !== SW'(10) || bus.stat_hits !== SW'(6)) begin
            bad++; $display("FAIL stats_totals got=%0d/%0d exp=10/6", bus.stat_lookups, bus.stat_hits);
        end
        cycle(1'b1, 16'h0010, 16'hFFFF, 1'b0, 1'b0, got, exp);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, got, exp);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, got, exp);
        total++;
        if (bus.stat_lookups !== SW'(0) || bus.stat_hits !== SW'(0)) begin
            bad++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", bus.stat_lookups, bus.stat_hits);
        end
        for (int i = 0; i < 42; i++) begin
            cycle(i < 40, NE'(16'h0800), 16'hFFFF, 1'b1, 1'b0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL stats_sat cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        total++;
        if (bus.stat_lookups !== SW'(SMAXI) || bus.stat_hits !== SW'(SMAXI)) begin
            bad++; $display("FAIL stats_saturate got=%0d/%0d exp=%0d/%0d",
                            bus.stat_lookups, bus.stat_hits, SMAXI, SMAXI);
        end
    endtask
`endif

    task automatic test_random();
        obs_t          got, exp;
        logic [NE-1:0] vec, ev;
        for (int i = 0; i < 600; i++) begin
            vec = NE'($urandom) & NE'($urandom) & NE'($urandom);
            ev  = NE'($urandom) | NE'($urandom);
            cycle($urandom_range(0, 3) != 0, vec, ev, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 40) == 0, got, exp);
            total++;
            if (got !== exp) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    initial begin
        bus.match_valid = 1'b0; bus.match_vec = '0; bus.entry_valid = '0;
        bus.result_ready = 1'b0; bus.stat_clear = 1'b0;
        test_reset();
        test_single();
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef TCAM_RESOLVER_STATS_EN
        test_stats();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
